// File: rtl/axis_fifo.sv
// AXI-stream FIFO with registered outputs, occupancy count and optional
// store-and-forward (packet) mode with a deadlock-break forced drain.
module axis_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 8,
  parameter int PACKET_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  up_axis_tdata,
  input  logic                   up_axis_tlast,
  input  logic                   up_axis_tvalid,
  output logic                   up_axis_tready,
  output logic [DATA_WIDTH-1:0]  dn_axis_tdata,
  output logic                   dn_axis_tlast,
  output logic                   dn_axis_tvalid,
  input  logic                   dn_axis_tready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Every accepted beat lives in mem until read; the output register mirrors
  // the head, so rd_ptr points at the oldest beat not yet presented.
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       pkt_cnt;
  logic                drain_q;

  logic          wr_en;
  logic          rd_en;
  logic          head_last;
  logic          pending;
  logic          forced;
  logic          eligible;
  logic          load_mem;
  logic          load_byp;
  logic [CW-1:0] count_next;
  logic [CW-1:0] unpresented;
  logic [CW-1:0] pkt_next;

  // NOTE: always_comb assigns every signal unconditionally, so no latch is inferred.
  always_comb begin
    wr_en       = up_axis_tvalid & up_axis_tready;
    rd_en       = dn_axis_tvalid & dn_axis_tready;
    head_last   = dn_axis_tvalid & dn_axis_tlast;
    count_next  = count + CW'(wr_en) - CW'(rd_en);
    unpresented = count - CW'(dn_axis_tvalid);
    pkt_next    = pkt_cnt + CW'(wr_en & up_axis_tlast) - CW'(rd_en & dn_axis_tlast);
    // A complete packet exists behind the head beat, ignoring a tlast already
    // sitting in the output register.
    pending     = (pkt_cnt - CW'(head_last)) != '0;
    // Forced drain ends with the packet's tlast beat, even before it is read.
    forced      = (drain_q | (count == FULL && pkt_cnt == '0)) & ~head_last;
    eligible    = (PACKET_MODE == 0) | pending | forced;
    load_mem    = (~dn_axis_tvalid | rd_en) & eligible & (unpresented != '0);
    // At count==1 with read and write, the incoming beat goes straight to the output.
    load_byp    = rd_en & wr_en & eligible & (unpresented == '0);
  end

  // NOTE: storage is not reset; pointers and count decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {up_axis_tlast, up_axis_tdata};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_axis_tready <= 1'b0;
      dn_axis_tvalid <= 1'b0;
      dn_axis_tlast  <= 1'b0;
      dn_axis_tdata  <= '0;
      count          <= '0;
      pkt_cnt        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      drain_q        <= 1'b0;
    end else begin
      count          <= count_next;
      up_axis_tready <= count_next < FULL;
      pkt_cnt        <= pkt_next;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);

      if (load_mem) begin
        {dn_axis_tlast, dn_axis_tdata} <= mem[rd_ptr];
        dn_axis_tvalid                 <= 1'b1;
        rd_ptr                         <= rd_ptr + AW'(1);
      end else if (load_byp) begin
        {dn_axis_tlast, dn_axis_tdata} <= {up_axis_tlast, up_axis_tdata};
        dn_axis_tvalid                 <= 1'b1;
        rd_ptr                         <= rd_ptr + AW'(1);
      end else if (rd_en) begin
        dn_axis_tvalid <= 1'b0;
      end

      if (rd_en && dn_axis_tlast) begin
        drain_q <= 1'b0;
      end else if (count == FULL && pkt_cnt == '0) begin
        drain_q <= (PACKET_MODE != 0);
      end
    end
  end

endmodule

// File: tb/tb_axis_fifo.sv
// Bench for axis_fifo: a cut-through and a packet-mode instance share stimulus
// and are each compared every cycle against a queue-level model.
module tb_axis_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic [7:0] up_data;
  logic       up_last;
  logic       dn_ready;

  logic       up_ready_w [2];
  logic [7:0] dn_data_w  [2];
  logic       dn_last_w  [2];
  logic       dn_valid_w [2];
  logic [3:0] cnt_w      [2];

  int checks   = 0;
  int failures = 0;

  logic [8:0] log0[$];
  logic [8:0] log1[$];
  int max0 = 0;
  int max1 = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar m = 0; m < 2; m++) begin : g_inst
    localparam int PM = m;

    axis_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .PACKET_MODE(PM)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .up_axis_tdata  (up_data),
      .up_axis_tlast  (up_last),
      .up_axis_tvalid (up_valid),
      .up_axis_tready (up_ready_w[m]),
      .dn_axis_tdata  (dn_data_w[m]),
      .dn_axis_tlast  (dn_last_w[m]),
      .dn_axis_tvalid (dn_valid_w[m]),
      .dn_axis_tready (dn_ready),
      .count          (cnt_w[m])
    );

    // Model: q holds every accepted beat {tlast,data}; pres says q[0] is on the output.
    logic [8:0] q[$];
    bit pres  = 1'b0;
    bit rdy   = 1'b0;
    bit drain = 1'b0;

    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        q.delete();
        pres  = 1'b0;
        rdy   = 1'b0;
        drain = 1'b0;
      end else begin : step
        bit wr, rd, head_done, no_last, full_nolast, elig, load;
        int pend, unpres;
        wr = up_valid && rdy;
        rd = pres && dn_ready;
        pend = 0;
        no_last = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
          if (q[i][8]) begin
            no_last = 1'b0;
            if (i >= (pres ? 1 : 0)) pend++;
          end
        end
        head_done   = pres && q[0][8];
        full_nolast = (q.size() == DEPTH) && no_last;
        elig   = (PM == 0) || (pend > 0) || ((drain || full_nolast) && !head_done);
        unpres = q.size() - (pres ? 1 : 0);
        load   = (!pres || rd) && elig && ((unpres > 0) || (rd && wr));
        if (rd && q[0][8]) drain = 1'b0;
        else if (full_nolast) drain = 1'b1;
        if (rd) void'(q.pop_front());
        if (wr) q.push_back({up_last, up_data});
        pres = load ? 1'b1 : (rd ? 1'b0 : pres);
        rdy  = q.size() < DEPTH;
      end
    end

    always @(negedge clk) begin
      string p;
      p = (PM != 0) ? "pk" : "ct";
      check($sformatf("%s up_tready", p), up_ready_w[m], rdy);
      check($sformatf("%s dn_tvalid", p), dn_valid_w[m], pres);
      check($sformatf("%s count", p), cnt_w[m], q.size());
      if (pres && q.size() > 0) begin
        check($sformatf("%s dn_tdata", p), dn_data_w[m], q[0][7:0]);
        check($sformatf("%s dn_tlast", p), dn_last_w[m], q[0][8]);
      end
    end
  end

  // Records the beat each instance hands over at the coming rising edge.
  always @(negedge clk) begin
    #3;
    if (rst && dn_ready && dn_valid_w[0]) log0.push_back({dn_last_w[0], dn_data_w[0]});
    if (rst && dn_ready && dn_valid_w[1]) log1.push_back({dn_last_w[1], dn_data_w[1]});
    if (int'(cnt_w[0]) > max0) max0 = int'(cnt_w[0]);
    if (int'(cnt_w[1]) > max1) max1 = int'(cnt_w[1]);
  end

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    max0 = 0;
    max1 = 0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input int sel);
    logic acc = 1'b0;
    up_valid = 1'b1;
    up_data  = d;
    up_last  = l;
    for (int c = 0; c < 64 && !acc; c++) begin
      acc = up_ready_w[sel];
      @(negedge clk); #1;
    end
    check("send accepted", acc, 1);
  endtask

  task automatic wait_empty();
    int c = 0;
    while (c < 300 && (cnt_w[0] != 0 || cnt_w[1] != 0 || dn_valid_w[0] || dn_valid_w[1])) begin
      @(negedge clk); #1;
      c++;
    end
    check("drain to empty", {cnt_w[0], cnt_w[1]}, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic acc;
    rst = 1'b1; up_valid = 1'b0; up_data = '0; up_last = 1'b0; dn_ready = 1'b0;
    #1 rst = 1'b0;

    // Reset then idle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        check("reset tready", up_ready_w[m], 0);
        check("reset tvalid", dn_valid_w[m], 0);
        check("reset count", cnt_w[m], 0);
        check("reset tdata", dn_data_w[m], 0);
      end
    end
    rst = 1'b1;
    @(negedge clk); #1;
    check("ct tready after release", up_ready_w[0], 1);
    check("pk tready after release", up_ready_w[1], 1);

    // Cut-through streaming 0x01..0x10.
    clear_logs();
    dn_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_beat(8'(i + 1), i == 15, 0);
      if (i == 0) check("ct beat not visible after 1 edge", dn_valid_w[0], 0);
      if (i == 1) begin
        check("ct beat visible after 2 edges", dn_valid_w[0], 1);
        check("ct first beat data", dn_data_w[0], 8'h01);
      end
    end
    up_valid = 1'b0;
    wait_empty();
    check("ct stream length", log0.size(), 16);
    for (int i = 0; i < 16 && i < log0.size(); i++)
      check("ct stream beat", log0[i], {i == 15, 8'(i + 1)});
    check("ct stream max count", max0, 2);

    // Fill and drain with 10 beats into 8 entries.
    clear_logs();
    dn_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      up_valid = 1'b1; up_data = 8'hA0 + 8'(idx); up_last = 1'b0;
      acc = up_ready_w[0];
      @(negedge clk); #1;
      if (acc) idx++;
    end
    check("fill accepted", idx, 8);
    check("fill count", cnt_w[0], 8);
    check("fill tready", up_ready_w[0], 0);
    check("fill head valid", dn_valid_w[0], 1);
    check("fill head data", dn_data_w[0], 8'hA0);
    dn_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      up_data = 8'hA0 + 8'(idx);
      acc = up_ready_w[0];
      @(negedge clk); #1;
      if (c == 0) begin
        check("tready after first read", up_ready_w[0], 1);
        check("count after first read", cnt_w[0], 7);
      end
      if (acc) idx++;
    end
    up_valid = 1'b0;
    wait_empty();
    check("drain length", log0.size(), 10);
    for (int i = 0; i < 10 && i < log0.size(); i++)
      check("drain beat", log0[i], {1'b0, 8'hA0 + 8'(i)});

    // Packet mode store-and-forward.
    pulse_reset();
    clear_logs();
    dn_ready = 1'b1;
    send_beat(8'h11, 1'b0, 1);
    up_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      check("pk held before tlast", dn_valid_w[1], 0);
    end
    send_beat(8'h22, 1'b0, 1);
    up_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      check("pk held before tlast", dn_valid_w[1], 0);
    end
    send_beat(8'h33, 1'b1, 1);
    up_valid = 1'b0;
    check("pk held at tlast write", dn_valid_w[1], 0);
    check("pk count 3", cnt_w[1], 3);
    @(negedge clk); #1;
    check("pk beat 1 valid", dn_valid_w[1], 1);
    check("pk beat 1", {dn_last_w[1], dn_data_w[1]}, 9'h011);
    @(negedge clk); #1;
    check("pk beat 2", {dn_valid_w[1], dn_last_w[1], dn_data_w[1]}, 10'h222);
    @(negedge clk); #1;
    check("pk beat 3", {dn_valid_w[1], dn_last_w[1], dn_data_w[1]}, 10'h333);
    wait_empty();
    check("pk packet length", log1.size(), 3);

    // Packet longer than the FIFO: forced drain.
    clear_logs();
    for (int i = 0; i < 12; i++) send_beat(8'h60 + 8'(i), i == 11, 1);
    up_valid = 1'b0;
    wait_empty();
    check("pk long length", log1.size(), 12);
    for (int i = 0; i < 12 && i < log1.size(); i++)
      check("pk long beat", log1[i], {i == 11, 8'h60 + 8'(i)});
    check("pk long max count", max1, 8);

    // Reset in the middle of operation.
    dn_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(8'h70 + 8'(i), 1'b0, 0);
    up_valid = 1'b0;
    check("ct count 5", cnt_w[0], 5);
    check("ct head valid before reset", dn_valid_w[0], 1);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("async reset tvalid", dn_valid_w[0], 0);
    check("async reset ct count", cnt_w[0], 0);
    check("async reset pk count", cnt_w[1], 0);
    @(negedge clk); #1;
    rst = 1'b1;
    clear_logs();
    dn_ready = 1'b1;
    send_beat(8'h5A, 1'b1, 0);
    up_valid = 1'b0;
    wait_empty();
    check("ct after reset length", log0.size(), 1);
    if (log0.size() > 0) check("ct after reset beat", log0[0], 9'h15A);
    check("pk after reset length", log1.size(), 1);
    if (log1.size() > 0) check("pk after reset beat", log1[0], 9'h15A);

    // Randomized traffic with varying downstream back-pressure.
    for (int blk = 0; blk < 10; blk++) begin
      int rp;
      rp = $urandom_range(1, 4);
      for (int c = 0; c < 200; c++) begin
        up_valid = $urandom_range(0, 3) != 0;
        up_data  = 8'($urandom);
        up_last  = $urandom_range(0, 4) == 0;
        dn_ready = $urandom_range(0, 4) < rp;
        @(negedge clk); #1;
      end
    end
    dn_ready = 1'b1;
    send_beat(8'hFF, 1'b1, 1);
    up_valid = 1'b0;
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
